sfq_jtl_chain: RTL and testbench
================================

Name: sfq_jtl_chain

Overview:
- Parametrised, multi-channel, cycle-based behavioural model of a Josephson transmission line chain for SFQ pulse-level simulation.
- Each channel carries single-cycle pulses and delays every accepted pulse by DELAY clock cycles.
- Each channel enforces a minimum pulse spacing, as a physical JTL does: a pulse arriving too close behind the previous one is dropped and flagged.
- Per-channel emitted-pulse counters support the pulse-accounting checks used by the team's benches.

Parameters:
- CH, 4: number of independent channels (>=1).
- DELAY, 3: pipeline latency in cycles from pulse_in to pulse_out (>=1).
- MIN_GAP, 2: minimum cycles between consecutive accepted pulses on one channel (>=1; 1 = back-to-back allowed).
- CNT_W, 8: width of each per-channel pulse counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  CH  per-channel input enable.
- pulse_in  in  CH  per-channel input pulse, one cycle high = one SFQ pulse.
- clr_flags  in  1  clears all drop_flag bits.
- pulse_out  out  CH  per-channel delayed pulse.
- drop_flag  out  CH  sticky spacing-violation flag per channel.
- pulse_cnt  out  CH*CNT_W  packed emitted-pulse counters; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset: while rst is high at a clock edge, clear all of the following to 0:
  - shift stages, gap counters, pulse_out, drop_flag, pulse_cnt.
  - rst overrides all other inputs, and in-flight pulses are discarded.
- Acceptance, channel i, edge t: a pulse is accepted iff en[i] && pulse_in[i] && gap_cnt[i]==0.
- Accepted pulse:
  - Enters stage 0 of an independent DELAY-deep shift register.
  - pulse_out[i] is high for exactly one cycle, DELAY edges after sampling (registered output).
- Gap counter:
  - Loaded with MIN_GAP-1 on acceptance; otherwise decrements toward 0 and saturates at 0.
  - With MIN_GAP=1 the counter is always 0.
- Drop:
  - Condition: en[i] && pulse_in[i] && gap_cnt[i]!=0.
  - The pulse is discarded and drop_flag[i] is set.
  - The gap counter is NOT reloaded, so the spacing is measured from the last accepted pulse.
- drop_flag:
  - Sticky until clr_flags or rst.
  - A new drop in the same cycle as clr_flags wins: the flag stays 1.
- Disabled channel (en[i]=0):
  - pulse_in is ignored and no drop is flagged.
  - In-flight pulses still drain to pulse_out; the gap counter still decrements.
- pulse_cnt[i]:
  - Increments by 1 on each cycle that pulse_out[i] is high.
  - Wraps modulo 2^CNT_W with no flag.
- Channels are fully independent; simultaneous pulses on several channels are all handled in the same cycle.
- No combinational path from any input to any output.

Decomposition:
- Package sfq_pkg holds:
  - Default-parameter constants (SFQ_DEF_CH, SFQ_DEF_DELAY, SFQ_DEF_MIN_GAP, SFQ_DEF_CNT_W).
  - A clog2-based width helper for the gap counter, which is max(1, clog2(MIN_GAP)) bits wide.
- One sub-module, sfq_jtl_lane, implements a single channel: shift register, gap counter, drop flag, counter.
- The top generates CH instances of sfq_jtl_lane and packs pulse_cnt.

Test Plan:
- Single pulse: rst 2 cycles, en=4'hF, pulse_in[0] at cycle 10 -> pulse_out[0] high only at the edge 3 cycles later; pulse_cnt ch0=1; all drop_flag=0.
- Spacing violation: MIN_GAP=2, pulses on ch1 at cycles 10 and 11 -> only the cycle-10 pulse emerges (at 13); drop_flag[1]=1; pulse_cnt ch1=1. Pulses at 10 and 12 -> both emerge (13, 15); no flag.
- Flag clear race: drop on ch2 in the same cycle as clr_flags -> drop_flag[2] stays 1. clr_flags alone one cycle later -> drop_flag[2]=0.
- Disable mid-flight: pulse ch3 at cycle 10, en[3]=0 from cycle 11, pulse_in[3] at 12 -> pulse at 13 emerges; the cycle-12 pulse is ignored; no flag.
- Counter wrap: CNT_W=8, 256 accepted pulses on ch0 spaced by 2 -> pulse_cnt ch0 returns to 0 after the 256th output.
- Reset mid-operation: pulses on all channels at cycle 10, rst at cycle 11 -> no pulse_out at 13; all counters and flags 0; a pulse at cycle 12 (rst low) emerges at 15.

Source files
------------

// File: rtl/sfq_pkg.sv
// sfq_pkg: shared defaults and the gap-counter width helper for the SFQ JTL chain
package sfq_pkg;
  localparam int SFQ_DEF_CH      = 4;
  localparam int SFQ_DEF_DELAY   = 3;
  localparam int SFQ_DEF_MIN_GAP = 2;
  localparam int SFQ_DEF_CNT_W   = 8;
  function automatic int gap_w(input int min_gap);
    return $clog2(min_gap) > 1 ? $clog2(min_gap) : 1;
  endfunction
endpackage

// File: rtl/sfq_jtl_lane.sv
// sfq_jtl_lane: one JTL channel - delay line, spacing guard, sticky drop flag, emitted-pulse counter
module sfq_jtl_lane
  import sfq_pkg::*;
#(
  parameter int DELAY   = SFQ_DEF_DELAY,
  parameter int MIN_GAP = SFQ_DEF_MIN_GAP,
  parameter int CNT_W   = SFQ_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse_in,
  input  logic             clr_flags,
  output logic             pulse_out,
  output logic             drop_flag,
  output logic [CNT_W-1:0] pulse_cnt
);
  localparam int GW = gap_w(MIN_GAP);
  localparam logic [GW-1:0] GAP_LD = GW'(MIN_GAP - 1);
  logic [DELAY-1:0] sr_q, sr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic req, acc;
  always_comb begin
    req = en && pulse_in;
    acc = req && gap_q == '0;
    sr_d = DELAY'({sr_q, acc});
    gap_d = acc ? GAP_LD : gap_q == '0 ? gap_q : gap_q - GW'(1);
    flag_d = (req && !acc) || (flag_q && !clr_flags);
    cnt_d = cnt_q + CNT_W'(sr_q[DELAY-1]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
      gap_q <= '0;
      flag_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sr_q <= sr_d;
      gap_q <= gap_d;
      flag_q <= flag_d;
      cnt_q <= cnt_d;
    end
  end
  assign pulse_out = sr_q[DELAY-1];
  assign drop_flag = flag_q;
  assign pulse_cnt = cnt_q;
endmodule

// File: rtl/sfq_jtl_chain.sv
// sfq_jtl_chain: CH independent JTL lanes with packed per-channel emitted-pulse counters
module sfq_jtl_chain
  import sfq_pkg::*;
#(
  parameter int CH      = SFQ_DEF_CH,
  parameter int DELAY   = SFQ_DEF_DELAY,
  parameter int MIN_GAP = SFQ_DEF_MIN_GAP,
  parameter int CNT_W   = SFQ_DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       en,
  input  logic [CH-1:0]       pulse_in,
  input  logic                clr_flags,
  output logic [CH-1:0]       pulse_out,
  output logic [CH-1:0]       drop_flag,
  output logic [CH*CNT_W-1:0] pulse_cnt
);
  for (genvar i = 0; i < CH; i++) begin : g_lane
    sfq_jtl_lane #(.DELAY(DELAY), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) u_lane (
      .clk(clk),
      .rst(rst),
      .en(en[i]),
      .pulse_in(pulse_in[i]),
      .clr_flags(clr_flags),
      .pulse_out(pulse_out[i]),
      .drop_flag(drop_flag[i]),
      .pulse_cnt(pulse_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_sfq_jtl_chain.sv
// tb_sfq_jtl_chain: scoreboard bench with a time-based reference model of the JTL chain
module tb_sfq_jtl_chain;
  localparam int CH = 4, DELAY = 3, MIN_GAP = 2, CNT_W = 8;
  logic clk = 1'b0, rst = 1'b1, clr_flags = 1'b0;
  logic [CH-1:0] en = '0, pulse_in = '0;
  logic [CH-1:0] pulse_out, drop_flag;
  logic [CH*CNT_W-1:0] pulse_cnt;
  int n_chk = 0, n_fail = 0;
  int e = 0;
  bit chk_en = 1'b0;
  int exp_q[CH][$];
  int acc_t[CH][$];
  int last_acc[CH];
  bit mflag[CH];

  sfq_jtl_chain #(.CH(CH), .DELAY(DELAY), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .pulse_in(pulse_in),
    .clr_flags(clr_flags),
    .pulse_out(pulse_out),
    .drop_flag(drop_flag),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d at edge %0d: got %0d expected %0d", nm, c, e, act, exp);
    end
  endtask

  task automatic model_step();
    e++;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        exp_q[c].delete();
        acc_t[c].delete();
        last_acc[c] = -1000;
        mflag[c] = 1'b0;
      end else begin
        bit req, ok;
        req = en[c] && pulse_in[c];
        ok = (e - last_acc[c]) >= MIN_GAP;
        if (req && ok) begin
          last_acc[c] = e;
          acc_t[c].push_back(e);
          exp_q[c].push_back(e + DELAY - 1);
        end
        mflag[c] = (req && !ok) || (mflag[c] && !clr_flags);
      end
    end
  endtask

  task automatic monitor_step();
    for (int c = 0; c < CH; c++) begin
      bit ep;
      int n;
      while (exp_q[c].size() > 0 && exp_q[c][0] < e) begin
        n_chk++;
        n_fail++;
        $display("FAIL pulse_out_missing ch%0d: got none expected pulse at edge %0d", c, exp_q[c][0]);
        void'(exp_q[c].pop_front());
      end
      ep = exp_q[c].size() > 0 && exp_q[c][0] == e;
      if (ep) void'(exp_q[c].pop_front());
      chk("pulse_out", c, 32'(pulse_out[c]), 32'(ep));
      chk("drop_flag", c, 32'(drop_flag[c]), 32'(mflag[c]));
      n = 0;
      foreach (acc_t[c][k]) if (acc_t[c][k] + DELAY <= e) n++;
      chk("pulse_cnt", c, 32'(pulse_cnt[c*CNT_W +: CNT_W]), 32'(n % (1 << CNT_W)));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) monitor_step();
  end

  task automatic step(input logic [CH-1:0] p, input logic [CH-1:0] ev = '1, input bit c = 1'b0, input bit r = 1'b0);
    @(negedge clk);
    pulse_in = p;
    en = ev;
    clr_flags = c;
    rst = r;
  endtask

  task automatic idle(input int n, input logic [CH-1:0] ev = '1);
    repeat (n) step('0, ev);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    step('0, '1, 1'b0, 1'b1);
    idle(3);
    chk("reset_cnt", 0, 32'(pulse_cnt), 32'd0);
    chk("reset_flag", 0, 32'(drop_flag), 32'd0);
    step(4'h1);
    idle(5);
    chk("single_cnt", 0, 32'(pulse_cnt[0 +: CNT_W]), 32'd1);
    chk("single_flag", 0, 32'(drop_flag), 32'd0);
    step(4'h2);
    step(4'h2);
    idle(5);
    chk("gap_drop_flag", 1, 32'(drop_flag[1]), 32'd1);
    chk("gap_drop_cnt", 1, 32'(pulse_cnt[CNT_W +: CNT_W]), 32'd1);
    step('0, '1, 1'b1);
    step(4'h2);
    step('0);
    step(4'h2);
    idle(5);
    chk("gap_ok_flag", 1, 32'(drop_flag[1]), 32'd0);
    chk("gap_ok_cnt", 1, 32'(pulse_cnt[CNT_W +: CNT_W]), 32'd3);
    step(4'h4);
    step(4'h4, '1, 1'b1);
    step('0);
    chk("clr_race_flag", 2, 32'(drop_flag[2]), 32'd1);
    step('0, '1, 1'b1);
    step('0);
    chk("clr_flag", 2, 32'(drop_flag[2]), 32'd0);
    idle(3);
    step(4'h8);
    step('0, 4'h7);
    step(4'h8, 4'h7);
    idle(5, 4'h7);
    chk("dis_cnt", 3, 32'(pulse_cnt[3*CNT_W +: CNT_W]), 32'd1);
    chk("dis_flag", 3, 32'(drop_flag[3]), 32'd0);
    for (int i = 0; i < 256; i++) begin
      step(4'h1);
      step('0);
    end
    idle(5);
    chk("wrap_cnt", 0, 32'(pulse_cnt[0 +: CNT_W]), 32'd1);
    step(4'hF);
    step('0, '1, 1'b0, 1'b1);
    step(4'hF);
    idle(5);
    for (int c = 0; c < CH; c++) chk("rst_mid_cnt", c, 32'(pulse_cnt[c*CNT_W +: CNT_W]), 32'd1);
    chk("rst_mid_flag", 0, 32'(drop_flag), 32'd0);
    for (int i = 0; i < 2000; i++)
      step(CH'($urandom) & CH'($urandom), CH'($urandom) | CH'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    idle(DELAY + 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
